// File: rtl/m_seq_ctrl.sv
// Sequencer in front of the M-extension ALU: drives operands and selects, runs 32-step
// restoring division one step per cycle and returns one result over valid/ready.
`ifndef MUX_ALUOUT_LENGTH
`define MUX_ALUOUT_LENGTH 2
`endif
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif

module m_seq_ctrl #(
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [3:0]                     in_op,
    input  logic [31:0]                    in_a,
    input  logic [31:0]                    in_b,
    input  logic                           kill,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_result,
    output logic [32:0]                    A,
    output logic [32:0]                    B,
    output logic [31:0]                    R,
    output logic [62:0]                    D,
    output logic [31:0]                    Z,
    output logic [`MUX_ALUOUT_LENGTH-1:0]  mux_aluout,
    output logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
    input  logic                           sub_neg,
    input  logic [31:0]                    sub_result,
    input  logic [31:0]                    div_rem,
    input  logic [31:0]                    div_rem_neg,
    input  logic [65:0]                    alu_out
);

    localparam int unsigned AluSelW = `MUX_ALUOUT_LENGTH;
    localparam int unsigned DivSelW = `MUX_DIV_REM_LENGTH;
    localparam logic [AluSelW-1:0] SelMult  = AluSelW'(0);
    localparam logic [AluSelW-1:0] SelAdder = AluSelW'(1);
    localparam logic [AluSelW-1:0] SelSubtr = AluSelW'(2);
    localparam logic [DivSelW-1:0] SelR     = DivSelW'(0);
    localparam logic [DivSelW-1:0] SelZ     = DivSelW'(1);
    localparam logic [4:0]         CntInit  = 5'(DIV_STEPS - 1);

    localparam logic [3:0] OpMul    = 4'd0;
    localparam logic [3:0] OpMulh   = 4'd1;
    localparam logic [3:0] OpMulhsu = 4'd2;
    localparam logic [3:0] OpMulhu  = 4'd3;
    localparam logic [3:0] OpDiv    = 4'd4;
    localparam logic [3:0] OpRem    = 4'd6;
    localparam logic [3:0] OpRemu   = 4'd7;
    localparam logic [3:0] OpModAdd = 4'd8;
    localparam logic [3:0] OpModSub = 4'd9;

    typedef enum logic [2:0] {StIdle, StExec, StDiv, StFin, StDone} state_e;

    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [32:0]         a_q, a_d, b_q, b_d;
    logic [31:0]         r_q, r_d, z_q, z_d, res_q, res_d;
    logic [62:0]         d_q, d_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [AluSelW-1:0]  alu_sel_q, alu_sel_d;

    logic        is_signed, is_rem, a_sx, b_sx;
    logic [31:0] a_abs, b_abs;
    logic        unused_alu_hi;

    assign unused_alu_hi = ^alu_out[65:64];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        z_d       = z_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        alu_sel_d = alu_sel_q;

        is_signed = (in_op == OpDiv) || (in_op == OpRem);
        is_rem    = in_op[1];
        a_sx      = (in_op == OpMul) || (in_op == OpMulh) || (in_op == OpMulhsu);
        b_sx      = (in_op == OpMul) || (in_op == OpMulh);
        a_abs     = (is_signed && in_a[31]) ? -in_a : in_a;
        b_abs     = (is_signed && in_b[31]) ? -in_b : in_b;

        if (kill) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d    = in_op;
                        neg_a_d = is_signed && in_a[31];
                        neg_b_d = is_signed && in_b[31];
                        if (in_op <= OpMulhu || in_op == OpModAdd || in_op == OpModSub) begin
                            a_d       = {a_sx & in_a[31], in_a};
                            b_d       = {b_sx & in_b[31], in_b};
                            alu_sel_d = (in_op == OpModAdd) ? SelAdder :
                                        (in_op == OpModSub) ? SelSubtr : SelMult;
                            state_d   = StExec;
                        end else if (in_op <= OpRemu) begin
                            if (in_b == 32'd0) begin
                                res_d   = is_rem ? in_a : 32'hFFFF_FFFF;
                                state_d = StDone;
                            end else if (is_signed && in_a == 32'h8000_0000 &&
                                         in_b == 32'hFFFF_FFFF) begin
                                res_d   = is_rem ? 32'd0 : 32'h8000_0000;
                                state_d = StDone;
                            end else begin
                                r_d     = a_abs;
                                d_d     = {b_abs, 31'd0};
                                z_d     = 32'd0;
                                cnt_d   = CntInit;
                                state_d = StDiv;
                            end
                        end else begin
                            res_d   = 32'd0;
                            state_d = StDone;
                        end
                    end
                end
                StExec: begin
                    res_d   = (op_q inside {OpMulh, OpMulhsu, OpMulhu}) ? alu_out[63:32]
                                                                        : alu_out[31:0];
                    state_d = StDone;
                end
                StDiv: begin
                    // Restoring step: keep R-D only when it did not go negative.
                    if (!sub_neg) begin
                        r_d = sub_result;
                        z_d = {z_q[30:0], 1'b1};
                    end else begin
                        z_d = {z_q[30:0], 1'b0};
                    end
                    d_d   = d_q >> 1;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = StFin;
                    end
                end
                StFin: begin
                    res_d   = (op_q[1] ? neg_a_q : (neg_a_q ^ neg_b_q)) ? div_rem_neg : div_rem;
                    state_d = StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            op_q      <= 4'd0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            a_q       <= 33'd0;
            b_q       <= 33'd0;
            r_q       <= 32'd0;
            z_q       <= 32'd0;
            d_q       <= 63'd0;
            cnt_q     <= 5'd0;
            res_q     <= 32'd0;
            alu_sel_q <= SelMult;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            z_q       <= z_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            alu_sel_q <= alu_sel_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign out_result  = res_q;
    assign A           = a_q;
    assign B           = b_q;
    assign R           = r_q;
    assign D           = d_q;
    assign Z           = z_q;
    assign mux_aluout  = alu_sel_q;
    assign mux_div_rem = (state_q == StFin && !op_q[1]) ? SelZ : SelR;

endmodule
